// File: rtl/dmrs_seq_gen.sv
// dmrs_seq_gen: NB-IoT single-tone uplink DMRS sequence generator.
// Streams r(n) = AMP*(1+j)*(1-2c(n))*w_u(n mod 16) for n = 0..seq_len-1 over a
// valid/ready interface. c(n) comes from an on-chip Gold generator that is
// warmed up by NC bits after each accepted start.
// Optional build macro DMRS_WARMUP_X4_EN: warm-up advances 4 bits per cycle
// (NC/4 cycles) instead of 1 bit per cycle. The sample stream is identical.
module dmrs_seq_gen #(
  parameter int DATA_W = 16,
  parameter int AMP    = 23170,
  parameter int LEN_W  = 16,
  parameter int NC     = 1600
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [30:0]              c_init,
  input  logic [3:0]               w_idx,
  input  logic [LEN_W-1:0]         seq_len,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_i,
  output logic signed [DATA_W-1:0] out_q,
  output logic [LEN_W-1:0]         out_idx,
  output logic                     done
);

`ifdef DMRS_WARMUP_X4_EN
  localparam int WARM_LOAD = NC / 4;
  if (NC % 4 != 0) begin : g_nc_chk
    $error("dmrs_seq_gen: NC must be a multiple of 4 with 4-bit warm-up");
  end
`else
  localparam int WARM_LOAD = NC;
`endif
  localparam int WARM_W = (WARM_LOAD > 0) ? $clog2(WARM_LOAD + 1) : 1;

  if (AMP >= (1 << (DATA_W - 1))) begin : g_amp_chk
    $error("dmrs_seq_gen: AMP does not fit in DATA_W-1 bits");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [30:0]         r_x1;
  logic [30:0]         r_x2;
  logic [30:0]         w_x1_warm;
  logic [30:0]         w_x2_warm;
  logic [WARM_W-1:0]   r_warm_cnt;
  logic [3:0]          r_w_idx;
  logic [LEN_W-1:0]    r_seq_len;
  logic [LEN_W-1:0]    r_n;
  logic                r_done;
  logic                w_accept;
  logic                w_last;
  logic                w_wbit;
  logic                w_sign;
  logic signed [DATA_W-1:0] w_amp;
  logic signed [DATA_W-1:0] w_sample;

  // Bit 0 holds x(k); the new bit x(k+31) enters at the top.
  function automatic logic [30:0] x1_step(input logic [30:0] x);
    return {x[3] ^ x[0], x[30:1]};
  endfunction

  function automatic logic [30:0] x2_step(input logic [30:0] x);
    return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
  endfunction

  assign w_accept = (r_state == S_STREAM) && out_ready;
  assign w_last   = (r_n == r_seq_len - LEN_W'(1));
  assign w_wbit   = ^(r_w_idx & r_n[3:0]);
  assign w_sign   = r_x1[0] ^ r_x2[0] ^ w_wbit;
  assign w_amp    = DATA_W'(AMP);
  assign w_sample = w_sign ? -w_amp : w_amp;

  // Outputs are forced to zero outside STREAM so reset clears them at once.
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_STREAM);
  assign out_i     = out_valid ? w_sample : '0;
  assign out_q     = out_valid ? w_sample : '0;
  assign out_idx   = out_valid ? r_n : '0;
  assign done      = r_done;

  // Warm-up advance of both LFSRs: 1 or 4 recursion steps per cycle.
  always_comb begin
    w_x1_warm = r_x1;
    w_x2_warm = r_x2;
`ifdef DMRS_WARMUP_X4_EN
    for (int k = 0; k < 4; k++) begin
      w_x1_warm = x1_step(w_x1_warm);
      w_x2_warm = x2_step(w_x2_warm);
    end
`else
    w_x1_warm = x1_step(r_x1);
    w_x2_warm = x2_step(r_x2);
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first means no path leaves w_state_nxt unassigned, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (start && (seq_len != '0)) w_state_nxt = S_WARMUP;
      S_WARMUP: if (r_warm_cnt == '0) w_state_nxt = S_STREAM;
      S_STREAM: if (w_accept && w_last) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture on start, warm-up stepping, per-acceptance advance, done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x1       <= '0;
      r_x2       <= '0;
      r_warm_cnt <= '0;
      r_w_idx    <= '0;
      r_seq_len  <= '0;
      r_n        <= '0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (seq_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_x1       <= 31'h1;
              r_x2       <= c_init;
              r_warm_cnt <= WARM_W'(WARM_LOAD);
              r_w_idx    <= w_idx;
              r_seq_len  <= seq_len;
              r_n        <= '0;
            end
          end
        end
        S_WARMUP: begin
          if (r_warm_cnt != '0) begin
            r_x1       <= w_x1_warm;
            r_x2       <= w_x2_warm;
            r_warm_cnt <= r_warm_cnt - WARM_W'(1);
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            r_x1 <= x1_step(r_x1);
            r_x2 <= x2_step(r_x2);
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_n <= r_n + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmrs_seq_gen.sv
// tb_dmrs_seq_gen: scoreboard bench for dmrs_seq_gen. Expected samples come
// from an array-based Gold model pushed at start and popped on acceptance.
module tb_dmrs_seq_gen;

  localparam int DATA_W = 16;
  localparam int AMP    = 23170;
  localparam int LEN_W  = 16;
  localparam int NC     = 1600;
`ifdef DMRS_WARMUP_X4_EN
  localparam int LAT = NC / 4 + 1;
`else
  localparam int LAT = NC + 1;
`endif

  typedef struct {
    logic [LEN_W-1:0]         idx;
    logic signed [DATA_W-1:0] val;
  } exp_t;

  logic                     clk;
  logic                     reset;
  logic                     start;
  logic [30:0]              c_init;
  logic [3:0]               w_idx;
  logic [LEN_W-1:0]         seq_len;
  logic                     busy;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;
  logic [LEN_W-1:0]         out_idx;
  logic                     done;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  dmrs_seq_gen #(
    .DATA_W(DATA_W),
    .AMP   (AMP),
    .LEN_W (LEN_W),
    .NC    (NC)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .c_init   (c_init),
    .w_idx    (w_idx),
    .seq_len  (seq_len),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_i    (out_i),
    .out_q    (out_q),
    .out_idx  (out_idx),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Golden model: bit-serial Gold recursion over plain arrays.
  task automatic push_expected(input logic [30:0] ci, input logic [3:0] wi, input int len);
    bit   x1[];
    bit   x2[];
    int   tot;
    exp_t e;
    tot = NC + len + 31;
    x1 = new[tot];
    x2 = new[tot];
    for (int k = 0; k < 31; k++) begin
      x1[k] = (k == 0);
      x2[k] = ci[k];
    end
    for (int m = 31; m < tot; m++) begin
      x1[m] = x1[m-28] ^ x1[m-31];
      x2[m] = x2[m-28] ^ x2[m-29] ^ x2[m-30] ^ x2[m-31];
    end
    for (int n = 0; n < len; n++) begin
      logic [3:0] nb;
      bit         s;
      nb    = 4'(n);
      s     = x1[n+NC] ^ x2[n+NC] ^ (^(wi & nb));
      e.idx = LEN_W'(n);
      e.val = s ? DATA_W'(-AMP) : DATA_W'(AMP);
      sb.push_back(e);
    end
  endtask

  // Drive a start request at the current negedge and queue its expected samples.
  task automatic launch(input logic [30:0] ci, input logic [3:0] wi, input int len);
    start   = 1'b1;
    c_init  = ci;
    w_idx   = wi;
    seq_len = LEN_W'(len);
    push_expected(ci, wi, len);
  endtask

  // Follow one run from the edge that samples start to its done pulse.
  task automatic collect(input int len, input bit stall, input bit poke, input int abort_at,
                         input bit chain, input logic [30:0] nci, input logic [3:0] nwi,
                         input int nlen);
    int   e, acc, spurious, budget;
    bit   first, held, last, poked;
    logic signed [DATA_W-1:0] h_i, h_q;
    logic [LEN_W-1:0]         h_idx;
    exp_t x;
    e = 0; acc = 0; spurious = 0; budget = LAT + 4 * len + 40;
    first = 1'b1; held = 1'b0; last = 1'b0; poked = 1'b0;
    @(negedge clk);
    while (!last) begin
      start = 1'b0;
      if (e > budget) begin
        check("timeout", e, budget);
        return;
      end
      if (done) spurious++;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (first) begin
          check("latency", e, LAT);
          first = 1'b0;
        end
        if (held) begin
          check("stall_i", out_i, h_i);
          check("stall_q", out_q, h_q);
          check("stall_idx", out_idx, h_idx);
        end
        if (acc == abort_at) begin
          #2 reset = 1'b1;
          #1;
          check("abort_valid", out_valid, 0);
          check("abort_i", out_i, 0);
          check("abort_q", out_q, 0);
          check("abort_idx", out_idx, 0);
          check("abort_busy", busy, 0);
          check("abort_done", done, 0);
          @(negedge clk);
          reset = 1'b0;
          @(negedge clk);
          check("abort_no_done", done, 0);
          sb.delete();
          return;
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
          end else begin
            x = sb.pop_front();
            check("out_i", out_i, x.val);
            check("out_q", out_q, x.val);
            check("out_idx", out_idx, x.idx);
          end
          acc++;
          held = 1'b0;
          if (acc == len) last = 1'b1;
        end else begin
          held  = 1'b1;
          h_i   = out_i;
          h_q   = out_q;
          h_idx = out_idx;
        end
      end
      if (poke && !poked && acc == len / 2 && out_valid) begin
        start   = 1'b1;
        c_init  = ~c_init;
        seq_len = LEN_W'(3);
        poked   = 1'b1;
      end
      @(negedge clk);
      e++;
    end
    check("done", done, 1);
    check("valid_after", out_valid, 0);
    check("busy_after", busy, 0);
    check("spurious_done", spurious, 0);
    check("accepts", acc, len);
    if (chain) begin
      launch(nci, nwi, nlen);
    end else begin
      repeat (3) @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_valid", out_valid, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    c_init    = '0;
    w_idx     = '0;
    seq_len   = '0;
    out_ready = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_i", out_i, 0);
    check("rst_q", out_q, 0);
    check("rst_idx", out_idx, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Plain run, then Walsh row 15, then random backpressure with an ignored start.
    launch(31'h0, 4'h0, 16);
    collect(16, 1'b0, 1'b0, -1, 1'b0, '0, '0, 0);
    launch(31'h0, 4'hF, 32);
    collect(32, 1'b0, 1'b0, -1, 1'b0, '0, '0, 0);
    launch(31'h12345, 4'h5, 40);
    collect(40, 1'b1, 1'b1, -1, 1'b0, '0, '0, 0);

    // Zero length: done on the next cycle, never valid, never busy.
    launch(31'h77, 4'h1, 0);
    @(negedge clk);
    start = 1'b0;
    check("zl_done", done, 1);
    check("zl_valid", out_valid, 0);
    check("zl_busy", busy, 0);
    @(negedge clk);
    check("zl_done_clr", done, 0);
    check("zl_busy2", busy, 0);

    // Restart in the done cycle.
    launch(31'h7, 4'h3, 8);
    collect(8, 1'b0, 1'b0, -1, 1'b1, 31'h5A5A5, 4'h9, 10);
    collect(10, 1'b0, 1'b0, -1, 1'b0, '0, '0, 0);

    // Abort at sample 5, then the full run from n = 0.
    launch(31'h1ABCDEF, 4'h6, 20);
    collect(20, 1'b0, 1'b0, 5, 1'b0, '0, '0, 0);
    launch(31'h1ABCDEF, 4'h6, 20);
    collect(20, 1'b0, 1'b0, -1, 1'b0, '0, '0, 0);

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
